// File: rtl/sweep_clear_ram.sv
// Single-port synchronous data RAM, cleared by a one-word-per-cycle sweep after reset or Clear.
// Optional macro SWEEP_RAM_RDW_BYPASS_EN selects write-first read-during-write (default read-first).
module sweep_clear_ram #(
    parameter int unsigned           DATA_W    = 8,
    parameter int unsigned           ADDR_W    = 8,
    parameter logic [DATA_W-1:0]     CLEAR_VAL = '0
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              Clear,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_data,
    output logic [DATA_W-1:0] MemData,
    output logic              RdValid,
    output logic              Ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_word;

    // Single write port shared by the sweep and the datapath keeps the array block-RAM friendly.
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = CLEAR_VAL;
        if (!reset && !Clear) begin
            if (state == CLEAR) begin
                we = 1'b1;
            end else if (MemWrite) begin
                we    = 1'b1;
                waddr = Address;
                wdata = Write_data;
            end
        end
    end

    always_ff @(posedge ph1) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SWEEP_RAM_RDW_BYPASS_EN
    // Read and write share Address, so a concurrent write always hits the word being read.
    always_comb begin
        rd_word = MemWrite ? Write_data : mem[Address];
    end
`else
    always_comb begin
        rd_word = mem[Address];
    end
`endif

    always_ff @(posedge ph1) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            MemData  <= '0;
            RdValid  <= 1'b0;
            Ready    <= 1'b0;
        end else if (Clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
            MemData  <= '0;
            RdValid  <= 1'b0;
            Ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    MemData  <= '0;
                    RdValid  <= 1'b0;
                    if (clr_addr == '1) begin
                        state <= RUN;
                        Ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (MemRead) begin
                        MemData <= rd_word;
                        RdValid <= 1'b1;
                    end else begin
                        MemData <= '0;
                        RdValid <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_clear_ram.sv
// Directed bench for sweep_clear_ram: default 8x256 instance plus a 16x16 instance with CLEAR_VAL=DEAD.
module tb_sweep_clear_ram;

    logic ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    logic       reset, Clear, MemRead, MemWrite;
    logic [7:0] Address, Write_data, MemData;
    logic       RdValid, Ready;

    logic        b_reset, b_Clear, b_rd, b_wr;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata, b_data;
    logic        b_valid, b_ready;

    sweep_clear_ram dut (
        .ph1(ph1), .reset(reset), .Clear(Clear), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .MemData(MemData), .RdValid(RdValid),
        .Ready(Ready)
    );

    sweep_clear_ram #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'hDEAD)) dut_small (
        .ph1(ph1), .reset(b_reset), .Clear(b_Clear), .MemRead(b_rd), .MemWrite(b_wr),
        .Address(b_addr), .Write_data(b_wdata), .MemData(b_data), .RdValid(b_valid),
        .Ready(b_ready)
    );

`ifdef SWEEP_RAM_RDW_BYPASS_EN
    localparam logic [7:0] RDW_EXP = 8'h99;
`else
    localparam logic [7:0] RDW_EXP = 8'h11;
`endif

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step;
        @(posedge ph1);
        #1;
    endtask

    task automatic count_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!Ready && n < 1000);
    endtask

    task automatic count_ready_small(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!b_ready && n < 100);
    endtask

    initial begin
        int n;
        reset = 1'b1; Clear = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; Write_data = '0;
        b_reset = 1'b1; b_Clear = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;

        vecs.push_back('{"rd_00_after_sweep", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{"rd_7f_after_sweep", 1'b1, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{"rd_ff_after_sweep", 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{"wr_10_a5",          1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0});
        vecs.push_back('{"wr_ff_3c",          1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0});
        vecs.push_back('{"rd_10",             1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1});
        vecs.push_back('{"rd_ff",             1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b1});
        vecs.push_back('{"idle_bus_zero",     1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{"wr_20_11",          1'b0, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0});
        vecs.push_back('{"rdw_20_99",         1'b1, 1'b1, 8'h20, 8'h99, RDW_EXP, 1'b1});
        vecs.push_back('{"rd_20_after_rdw",   1'b1, 1'b0, 8'h20, 8'h00, 8'h99, 1'b1});
        vecs.push_back('{"rd_10_again",       1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1});

        // Test 1: reset held two cycles, then a full 256-cycle sweep.
        step();
        step();
        check("reset_ready", Ready, 0);
        check("reset_rdvalid", RdValid, 0);
        check("reset_memdata", MemData, 0);
        reset = 1'b0;
        MemRead = 1'b1;
        count_ready(n);
        check("sweep_cycles", n, 256);
        check("sweep_memdata_zero", MemData, 0);
        MemRead = 1'b0;

        // Tests 2/3: table-driven accesses in RUN.
        foreach (vecs[i]) begin
            MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
            Address = vecs[i].addr; Write_data = vecs[i].wdata;
            step();
            check({vecs[i].name, "_data"}, MemData, vecs[i].exp_data);
            check({vecs[i].name, "_valid"}, RdValid, vecs[i].exp_valid);
        end
        MemRead = 1'b0; MemWrite = 1'b0;

        // Test 4: accesses during a Clear-triggered sweep are dropped.
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("clear_ready_low", Ready, 0);
        MemWrite = 1'b1; Address = 8'h05; Write_data = 8'h55;
        step();
        MemWrite = 1'b0; MemRead = 1'b1;
        step();
        check("sweep_read_valid", RdValid, 0);
        check("sweep_read_data", MemData, 0);
        MemRead = 1'b0;
        count_ready(n);
        check("clear_sweep_remaining", n, 254);
        MemRead = 1'b1; Address = 8'h05;
        step();
        check("dropped_write_05", MemData, 0);
        check("dropped_write_valid", RdValid, 1);
        Address = 8'h10;
        step();
        check("clear_wiped_10", MemData, 0);
        MemRead = 1'b0;

        // Test 5: reset at clr_addr=100 restarts the sweep.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (100) step();
        check("mid_sweep_ready_low", Ready, 0);
        reset = 1'b1;
        step();
        check("mid_sweep_reset_ready", Ready, 0);
        reset = 1'b0;
        count_ready(n);
        check("restart_sweep_cycles", n, 256);

        // Test 6: 16x16 instance cleared to DEAD.
        step();
        b_reset = 1'b0;
        count_ready_small(n);
        check("small_sweep_cycles", n, 16);
        b_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_addr = 4'(i);
            step();
            check($sformatf("small_rd_%0d", i), b_data, 16'hDEAD);
        end
        check("small_valid", b_valid, 1);
        b_rd = 1'b0;
        step();
        check("small_idle_zero", b_data, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
